// File: rtl/arm7tdmi_pkg.sv
// arm7tdmi_pkg: branch kinds, branch-unit states and the ARM condition evaluator
// shared by the branch unit and the ALU condition check.
package arm7tdmi_pkg;
   typedef enum logic [2:0] {
      BR_B, BR_BL, BR_BX, BR_T_B, BR_T_BCC, BR_T_BL_HI, BR_T_BL_LO
   } branch_kind_t;
   typedef enum logic [1:0] {IDLE, BLWAIT, REDIR, REFILL} br_state_t;
   typedef struct packed {
      logic redirect;
      logic thumb;
      logic flush;
      logic lr_we;
      logic taken;
      logic resolved;
   } br_flags_t;
   localparam logic [3:0] COND_AL = 4'hE;
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/arm7tdmi_branch_target.sv
// arm7tdmi_branch_target: combinational target, link and T-state computation
// for every branch kind; address arithmetic wraps modulo 2^ADDR_W.
module arm7tdmi_branch_target
   import arm7tdmi_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter bit THUMB_EN = 1'b1
) (
   input  branch_kind_t      kind_i,
   input  logic [23:0]       offset_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] rm_i,
   input  logic [ADDR_W-1:0] prefix_i,
   output logic [ADDR_W-1:0] target_o,
   output logic [ADDR_W-1:0] link_o,
   output logic              link_we_o,
   output logic              thumb_o
);
   logic [ADDR_W-1:0] sx24, sx11, sx8, zx11;
   assign sx24 = ADDR_W'($signed(offset_i[23:0]));
   assign sx11 = ADDR_W'($signed(offset_i[10:0]));
   assign sx8  = ADDR_W'($signed(offset_i[7:0]));
   assign zx11 = ADDR_W'(offset_i[10:0]);
   always_comb begin
      target_o  = pc_i + ADDR_W'(8) + (sx24 << 2);
      link_o    = pc_i + ADDR_W'(4);
      link_we_o = 1'b0;
      thumb_o   = 1'b0;
      case (kind_i)
         BR_BL: link_we_o = 1'b1;
         BR_BX: begin
            target_o = rm_i[0] ? {rm_i[ADDR_W-1:1], 1'b0} : {rm_i[ADDR_W-1:2], 2'b00};
            thumb_o  = THUMB_EN && rm_i[0];
         end
         BR_T_B: begin
            target_o = pc_i + ADDR_W'(4) + (sx11 << 1);
            thumb_o  = THUMB_EN;
         end
         BR_T_BCC: begin
            target_o = pc_i + ADDR_W'(4) + (sx8 << 1);
            thumb_o  = THUMB_EN;
         end
         BR_T_BL_HI: begin
            link_o    = pc_i + ADDR_W'(4) + (sx11 << 12);
            link_we_o = 1'b1;
         end
         BR_T_BL_LO: begin
            target_o  = prefix_i + (zx11 << 1);
            link_o    = (pc_i + ADDR_W'(2)) | ADDR_W'(1);
            link_we_o = 1'b1;
            thumb_o   = THUMB_EN;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/arm7tdmi_branch_unit.sv
// arm7tdmi_branch_unit: execute-stage branch resolver; registers a one-cycle
// redirect/flush to fetch and holds off new branches while the prefetch refills.
module arm7tdmi_branch_unit
   import arm7tdmi_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter bit THUMB_EN     = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              br_valid,
   output logic              br_ready,
   input  branch_kind_t      br_kind,
   input  logic [3:0]        br_cond,
   input  logic [23:0]       br_offset,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [ADDR_W-1:0] rm_value,
   input  logic [3:0]        flags_nzcv,
   input  logic              flush_in,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              redirect_thumb,
   output logic              flush,
   output logic              lr_we,
   output logic [ADDR_W-1:0] lr_value,
   output logic              taken,
   output logic              resolved,
   output logic              busy
);
   localparam int CW = FLUSH_CYCLES > 0 ? $clog2(FLUSH_CYCLES + 1) : 1;
   br_state_t         state_q, state_d;
   br_flags_t         flg_q, flg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] prefix_q, prefix_d, pc_q, pc_d, lr_q, lr_d, tgt, link;
   logic              link_we, tgt_thumb, is_thumb, use_cond, pass, accept;

   arm7tdmi_branch_target #(.ADDR_W(ADDR_W), .THUMB_EN(THUMB_EN)) u_target (
      .kind_i    (br_kind),
      .offset_i  (br_offset),
      .pc_i      (br_pc),
      .rm_i      (rm_value),
      .prefix_i  (prefix_q),
      .target_o  (tgt),
      .link_o    (link),
      .link_we_o (link_we),
      .thumb_o   (tgt_thumb)
   );

   assign br_ready = state_q inside {IDLE, BLWAIT};
   assign busy     = state_q inside {REDIR, REFILL};

   always_comb begin
      is_thumb = br_kind inside {BR_T_B, BR_T_BCC, BR_T_BL_HI, BR_T_BL_LO};
      use_cond = br_kind inside {BR_B, BR_BL, BR_BX, BR_T_BCC};
      pass     = (THUMB_EN || !is_thumb) && cond_pass(use_cond ? br_cond : COND_AL, flags_nzcv);
      accept   = br_valid && br_ready && !flush_in;
      state_d  = state_q;
      cnt_d    = cnt_q;
      prefix_d = prefix_q;
      flg_d    = '0;
      pc_d     = '0;
      lr_d     = '0;
      case (state_q)
         IDLE, BLWAIT: if (accept) begin
            flg_d.resolved = 1'b1;
            if (br_kind == BR_T_BL_HI && THUMB_EN) begin
               prefix_d    = link;
               lr_d        = link;
               flg_d.lr_we = 1'b1;
               state_d     = BLWAIT;
            end else begin
               // a non-LO branch after a BL prefix abandons the pair
               if (state_q == BLWAIT && br_kind != BR_T_BL_LO) prefix_d = '0;
               flg_d.taken    = pass;
               flg_d.redirect = pass;
               flg_d.flush    = pass;
               flg_d.thumb    = pass && tgt_thumb;
               flg_d.lr_we    = pass && link_we;
               pc_d           = pass ? tgt : '0;
               lr_d           = (pass && link_we) ? link : '0;
               state_d        = pass ? REDIR : IDLE;
            end
         end
         REDIR: begin
            state_d = FLUSH_CYCLES == 0 ? IDLE : REFILL;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
         end
         REFILL: begin
            state_d = cnt_q == '0 ? IDLE : REFILL;
            cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (flush_in) begin
         state_d  = IDLE;
         prefix_d = '0;
         flg_d    = '0;
         pc_d     = '0;
         lr_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         prefix_q <= '0;
         flg_q    <= '0;
         pc_q     <= '0;
         lr_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prefix_q <= prefix_d;
         flg_q    <= flg_d;
         pc_q     <= pc_d;
         lr_q     <= lr_d;
      end
   end

   assign redirect_valid = flg_q.redirect;
   assign redirect_pc    = pc_q;
   assign redirect_thumb = flg_q.thumb;
   assign flush          = flg_q.flush;
   assign lr_we          = flg_q.lr_we;
   assign lr_value       = lr_q;
   assign taken          = flg_q.taken;
   assign resolved       = flg_q.resolved;
endmodule
